// File: rtl/crc_pkg.sv
// Shared definitions for the CRC generator/checker family: default widths,
// FSM state encoding and a beat-counter width helper.
package crc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CRC_W_DEF  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a counter that indexes the DATA_W/2 two-bit beats of a message.
  function automatic int beat_cnt_w(input int data_w);
    return (data_w / 2 > 1) ? $clog2(data_w / 2) : 1;
  endfunction

endpackage

// File: rtl/crc_step2.sv
// Combinational CRC update over two message bits (bits[1] first), no reflection.
// Shared by the generator and the checker so both use identical arithmetic.
module crc_step2 #(
  parameter int CRC_W = 5
) (
  input  logic [CRC_W-1:0] rem,
  input  logic [1:0]       bits,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] rem_next
);

  function automatic logic [CRC_W-1:0] bit_step(
    input logic [CRC_W-1:0] r,
    input logic             b,
    input logic [CRC_W-1:0] p
  );
    logic fb;
    fb = r[CRC_W-1] ^ b;
    return {r[CRC_W-2:0], 1'b0} ^ (fb ? p : {CRC_W{1'b0}});
  endfunction

  logic [CRC_W-1:0] mid_s;

  // Two chained serial steps, MSB of the pair first.
  always_comb begin
    mid_s    = bit_step(rem, bits[1], poly);
    rem_next = bit_step(mid_s, bits[0], poly);
  end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC checker: captures a message word, its CRC and the generator
// polynomial, recomputes the CRC two bits per clock and reports the syndrome.
module crc_check
  import crc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CRC_W  = CRC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_in,
  input  logic              data_in_valid,
  output logic              data_in_ready,
  input  logic [CRC_W:0]    poly,
  input  logic              poly_in_valid,
  output logic              poly_in_ready,
  output logic [CRC_W-1:0]  syndrome,
  output logic              crc_ok,
  output logic              outvalid,
  input  logic              outready
);

  localparam int               CNT_W     = beat_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_W / 2 - 1);

  logic [1:0]        state_r,     state_s;
  logic              have_data_r, have_data_s;
  logic              have_poly_r, have_poly_s;
  logic [DATA_W-1:0] data_r,      data_s;
  logic [CRC_W-1:0]  crc_r,       crc_s;
  logic [CRC_W-1:0]  poly_r,      poly_s;
  logic [CRC_W-1:0]  rem_r,       rem_s;
  logic [CNT_W-1:0]  cnt_r,       cnt_s;
  logic              fin_r,       fin_s;
  logic              data_rdy_r,  data_rdy_s;
  logic              poly_rdy_r,  poly_rdy_s;
  logic              outvalid_r,  outvalid_s;
  logic [CRC_W-1:0]  syndrome_r,  syndrome_s;
  logic              crc_ok_r,    crc_ok_s;

  logic              data_cap_s;
  logic              poly_cap_s;
  logic [CRC_W-1:0]  rem_step_s;
  logic              poly_msb_unused_s;

  // The x^CRC_W term of the generator is always present, so its bit is ignored.
  assign poly_msb_unused_s = poly[CRC_W];

  crc_step2 #(.CRC_W(CRC_W)) u_step (
    .rem      (rem_r),
    .bits     (data_r[DATA_W-1 -: 2]),
    .poly     (poly_r),
    .rem_next (rem_step_s)
  );

  // Next-state logic for the capture / compute / report sequence.
  always_comb begin
    state_s     = state_r;
    have_data_s = have_data_r;
    have_poly_s = have_poly_r;
    data_s      = data_r;
    crc_s       = crc_r;
    poly_s      = poly_r;
    rem_s       = rem_r;
    cnt_s       = cnt_r;
    fin_s       = fin_r;
    data_rdy_s  = data_rdy_r;
    poly_rdy_s  = poly_rdy_r;
    outvalid_s  = outvalid_r;
    syndrome_s  = syndrome_r;
    crc_ok_s    = crc_ok_r;
    data_cap_s  = 1'b0;
    poly_cap_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        data_cap_s = data_in_valid & data_rdy_r;
        poly_cap_s = poly_in_valid & poly_rdy_r;
        if (data_cap_s) begin
          data_s = data_in;
          crc_s  = crc_in;
        end else begin
          data_s = data_r;
          crc_s  = crc_r;
        end
        if (poly_cap_s) begin
          poly_s = poly[CRC_W-1:0];
        end else begin
          poly_s = poly_r;
        end
        have_data_s = have_data_r | data_cap_s;
        have_poly_s = have_poly_r | poly_cap_s;
        if (have_data_s & have_poly_s) begin
          state_s    = ST_CALC;
          data_rdy_s = 1'b0;
          poly_rdy_s = 1'b0;
          rem_s      = {CRC_W{1'b0}};
          cnt_s      = {CNT_W{1'b0}};
          fin_s      = 1'b0;
        end else begin
          data_rdy_s = ~have_data_s;
          poly_rdy_s = ~have_poly_s;
        end
      end

      ST_CALC: begin
        data_rdy_s = 1'b0;
        poly_rdy_s = 1'b0;
        // One extra cycle after the last beat registers the result.
        if (fin_r) begin
          state_s    = ST_DONE;
          syndrome_s = rem_r ^ crc_r;
          crc_ok_s   = ((rem_r ^ crc_r) == {CRC_W{1'b0}});
          outvalid_s = 1'b1;
          fin_s      = 1'b0;
        end else begin
          rem_s  = rem_step_s;
          data_s = {data_r[DATA_W-3:0], 2'b00};
          cnt_s  = cnt_r + CNT_W'(1);
          fin_s  = (cnt_r == LAST_BEAT);
        end
      end

      ST_DONE: begin
        if (outready) begin
          state_s     = ST_IDLE;
          outvalid_s  = 1'b0;
          data_rdy_s  = 1'b1;
          poly_rdy_s  = 1'b1;
          have_data_s = 1'b0;
          have_poly_s = 1'b0;
        end else begin
          state_s     = ST_DONE;
          outvalid_s  = 1'b1;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        have_data_s = 1'b0;
        have_poly_s = 1'b0;
        data_rdy_s  = 1'b0;
        poly_rdy_s  = 1'b0;
        outvalid_s  = 1'b0;
        fin_s       = 1'b0;
      end
    endcase
  end

  // All state, with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      have_data_r <= 1'b0;
      have_poly_r <= 1'b0;
      data_r      <= {DATA_W{1'b0}};
      crc_r       <= {CRC_W{1'b0}};
      poly_r      <= {CRC_W{1'b0}};
      rem_r       <= {CRC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      fin_r       <= 1'b0;
      data_rdy_r  <= 1'b0;
      poly_rdy_r  <= 1'b0;
      outvalid_r  <= 1'b0;
      syndrome_r  <= {CRC_W{1'b0}};
      crc_ok_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      have_data_r <= have_data_s;
      have_poly_r <= have_poly_s;
      data_r      <= data_s;
      crc_r       <= crc_s;
      poly_r      <= poly_s;
      rem_r       <= rem_s;
      cnt_r       <= cnt_s;
      fin_r       <= fin_s;
      data_rdy_r  <= data_rdy_s;
      poly_rdy_r  <= poly_rdy_s;
      outvalid_r  <= outvalid_s;
      syndrome_r  <= syndrome_s;
      crc_ok_r    <= crc_ok_s;
    end
  end

  assign data_in_ready = data_rdy_r;
  assign poly_in_ready = poly_rdy_r;
  assign outvalid      = outvalid_r;
  assign syndrome      = syndrome_r;
  assign crc_ok        = crc_ok_r;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: directed vectors plus randomized jobs
// compared against a polynomial long-division reference model.
module tb_crc_check;

  localparam int DW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] crc_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [CW:0]   poly = '0;
  logic          poly_in_valid = 1'b0;
  logic          poly_in_ready;
  logic [CW-1:0] syndrome;
  logic          crc_ok;
  logic          outvalid;
  logic          outready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crc_check #(.DATA_W(DW), .CRC_W(CW)) dut (
    .clk(clk), .reset(reset),
    .data_in(data_in), .crc_in(crc_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .poly(poly), .poly_in_valid(poly_in_valid), .poly_in_ready(poly_in_ready),
    .syndrome(syndrome), .crc_ok(crc_ok), .outvalid(outvalid), .outready(outready)
  );

  // Remainder of M(x)*x^CW divided by G(x) via long division.
  function automatic logic [CW-1:0] ref_crc(input logic [DW-1:0] d, input logic [CW:0] p);
    logic [DW+CW-1:0] m;
    logic [CW:0]      g;
    g = {1'b1, p[CW-1:0]};
    m = {d, {CW{1'b0}}};
    for (int i = DW + CW - 1; i >= CW; i--) begin
      if (m[i]) m[i -: CW + 1] = m[i -: CW + 1] ^ g;
    end
    return m[CW-1:0];
  endfunction

  // Mode 0: both together; 1: poly first; 2: data first. Returns #1 after the final capture edge.
  task automatic start_job(input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic [CW:0] p, input int mode, input int gap);
    @(negedge clk);
    if (mode == 0) begin
      data_in = d; crc_in = c; poly = p;
      data_in_valid = 1'b1; poly_in_valid = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0; poly_in_valid = 1'b0;
    end else if (mode == 1) begin
      poly = p; poly_in_valid = 1'b1;
      @(posedge clk); #1;
      poly_in_valid = 1'b0; poly = 6'($urandom);
      repeat (gap) @(posedge clk);
      #1;
      data_in = d; crc_in = c; data_in_valid = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
    end else begin
      data_in = d; crc_in = c; data_in_valid = 1'b1;
      @(posedge clk); #1;
      data_in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      poly = p; poly_in_valid = 1'b1;
      @(posedge clk); #1;
      poly_in_valid = 1'b0;
    end
    data_in = DW'($urandom); crc_in = CW'($urandom); poly = 6'($urandom);
  endtask

  task automatic wait_result(output int lat, output bit timeout);
    lat = 0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (outvalid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept_result();
    outready = 1'b1;
    @(posedge clk); #1;
    outready = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%b exp=0", data_in_ready); end
    total++; if (poly_in_ready !== 1'b0) begin bad++; $display("FAIL reset_poly_ready got=%b exp=0", poly_in_ready); end
    total++; if (outvalid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b exp=0", outvalid); end
    total++; if (syndrome !== 5'h00) begin bad++; $display("FAIL reset_syndrome got=%h exp=00", syndrome); end
    total++; if (crc_ok !== 1'b0) begin bad++; $display("FAIL reset_crc_ok got=%b exp=0", crc_ok); end
    @(negedge clk); reset = 1'b1;
    #1;
    total++; if (data_in_ready !== 1'b0) begin bad++; $display("FAIL release_pre_edge_ready got=%b exp=0", data_in_ready); end
    @(posedge clk); #1;
    total++; if ({data_in_ready, poly_in_ready} !== 2'b11) begin bad++; $display("FAIL release_readies got=%b exp=11", {data_in_ready, poly_in_ready}); end
  endtask

  task automatic test_known_vectors();
    logic [CW-1:0] crcs [2];
    logic [CW-1:0] syns [2];
    int  lat;
    bit  to;
    crcs[0] = 5'h05; syns[0] = 5'h00;
    crcs[1] = 5'h04; syns[1] = 5'h01;
    for (int k = 0; k < 2; k++) begin
      start_job(32'h0000_0001, crcs[k], 6'b100101, 0, 0);
      wait_result(lat, to);
      total++; if (to || lat != 17) begin bad++; $display("FAIL known_latency[%0d] got=%0d exp=17 timeout=%0b", k, lat, to); end
      total++; if (syndrome !== syns[k]) begin bad++; $display("FAIL known_syndrome[%0d] got=%h exp=%h", k, syndrome, syns[k]); end
      total++; if (crc_ok !== (syns[k] == 5'h00)) begin bad++; $display("FAIL known_crc_ok[%0d] got=%b exp=%b", k, crc_ok, syns[k] == 5'h00); end
      accept_result();
      total++; if (outvalid !== 1'b0) begin bad++; $display("FAIL known_drop_outvalid[%0d] got=%b exp=0", k, outvalid); end
    end
  endtask

  task automatic test_poly_first();
    int lat;
    bit to;
    @(negedge clk);
    poly = 6'b100101; poly_in_valid = 1'b1;
    @(posedge clk); #1;
    poly_in_valid = 1'b0; poly = 6'b011010;
    total++; if ({poly_in_ready, data_in_ready} !== 2'b01) begin bad++; $display("FAIL polyfirst_readies got=%b exp=01", {poly_in_ready, data_in_ready}); end
    repeat (2) @(posedge clk);
    #1;
    total++; if ({poly_in_ready, data_in_ready} !== 2'b01) begin bad++; $display("FAIL polyfirst_wait_readies got=%b exp=01", {poly_in_ready, data_in_ready}); end
    data_in = 32'h0000_0002; crc_in = 5'h0A; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    total++; if ({poly_in_ready, data_in_ready} !== 2'b00) begin bad++; $display("FAIL polyfirst_calc_readies got=%b exp=00", {poly_in_ready, data_in_ready}); end
    wait_result(lat, to);
    total++; if (to || lat != 17) begin bad++; $display("FAIL polyfirst_latency got=%0d exp=17", lat); end
    total++; if (syndrome !== 5'h00 || crc_ok !== 1'b1) begin bad++; $display("FAIL polyfirst_result got=%h/%b exp=00/1", syndrome, crc_ok); end
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    bit to;
    int err;
    start_job(32'hDEAD_BEEF, 5'h00, 6'b110111, 0, 0);
    wait_result(lat, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=timeout exp=outvalid"); end
    err = 0;
    for (int i = 0; i < 10; i++) begin
      data_in_valid = 1'($urandom); poly_in_valid = 1'($urandom);
      @(posedge clk); #1;
      if (outvalid !== 1'b1 || syndrome !== ref_crc(32'hDEAD_BEEF, 6'b110111) ||
          crc_ok !== (ref_crc(32'hDEAD_BEEF, 6'b110111) == 5'h00) ||
          {data_in_ready, poly_in_ready} !== 2'b00) err++;
    end
    data_in_valid = 1'b0; poly_in_valid = 1'b0;
    total++; if (err != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable cycles exp=0 (syn=%h)", err, syndrome); end
    accept_result();
    total++; if ({outvalid, data_in_ready, poly_in_ready} !== 3'b011) begin bad++; $display("FAIL bp_release got=%b exp=011", {outvalid, data_in_ready, poly_in_ready}); end
  endtask

  task automatic test_reset_mid_calc();
    int  lat;
    bit  to;
    bit  seen;
    start_job(32'h1234_5678, 5'h1F, 6'b100101, 0, 0);
    repeat (8) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++; if ({data_in_ready, poly_in_ready, outvalid, crc_ok} !== 4'b0000 || syndrome !== 5'h00) begin
      bad++; $display("FAIL midreset_outputs got=%b/%h exp=0000/00", {data_in_ready, poly_in_ready, outvalid, crc_ok}, syndrome); end
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (outvalid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_result got=%b exp=0", seen); end
    start_job(32'h1234_5678, ref_crc(32'h1234_5678, 6'b100101), 6'b100101, 0, 0);
    wait_result(lat, to);
    total++; if (to || lat != 17 || syndrome !== 5'h00 || crc_ok !== 1'b1) begin
      bad++; $display("FAIL midreset_rerun got=lat%0d syn=%h ok=%b exp=lat17 syn=00 ok=1", lat, syndrome, crc_ok); end
    accept_result();
  endtask

  task automatic test_zero_and_ignore();
    logic [CW:0] p;
    int          early;
    p = 6'($urandom);
    start_job(32'h0, 5'h00, p, 0, 0);
    early = 0;
    for (int i = 1; i <= 17; i++) begin
      if (i < 16) begin
        data_in = DW'($urandom); crc_in = CW'($urandom); poly = 6'($urandom);
        data_in_valid = 1'($urandom); poly_in_valid = 1'($urandom); outready = 1'($urandom);
      end else begin
        data_in_valid = 1'b0; poly_in_valid = 1'b0; outready = 1'b0;
      end
      @(posedge clk); #1;
      if (i < 17 && outvalid) early++;
    end
    total++; if (early != 0 || outvalid !== 1'b1) begin bad++; $display("FAIL zero_timing got=early%0d ov=%b exp=early0 ov=1", early, outvalid); end
    total++; if (syndrome !== 5'h00 || crc_ok !== 1'b1) begin bad++; $display("FAIL zero_result got=%h/%b exp=00/1", syndrome, crc_ok); end
    accept_result();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [CW:0]   p;
    logic [CW-1:0] exp_syn;
    int            lat;
    bit            to;
    for (int n = 0; n < 30; n++) begin
      d = DW'($urandom);
      p = 6'($urandom);
      c = ($urandom_range(1, 0) == 1) ? ref_crc(d, p) : CW'($urandom);
      exp_syn = ref_crc(d, p) ^ c;
      start_job(d, c, p, $urandom_range(2, 0), $urandom_range(4, 0));
      wait_result(lat, to);
      total++; if (to || lat != 17) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=17", n, lat); end
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
      total++; if (syndrome !== exp_syn || crc_ok !== (exp_syn == 5'h00)) begin
        bad++; $display("FAIL rand_result[%0d] got=%h/%b exp=%h/%b d=%h p=%b", n, syndrome, crc_ok, exp_syn, exp_syn == 5'h00, d, p); end
      accept_result();
      total++; if ({outvalid, data_in_ready, poly_in_ready} !== 3'b011) begin bad++; $display("FAIL rand_release[%0d] got=%b exp=011", n, {outvalid, data_in_ready, poly_in_ready}); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_poly_first();
    test_backpressure();
    test_reset_mid_calc();
    test_zero_and_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_check.md
CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 Parameter DATA_W, default 32, message width in bits; SHALL be even.
REQ-002 Parameter CRC_W, default 5, CRC width; poly width is CRC_W+1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 data_in  input  DATA_W  received message word, MSB transmitted first.
REQ-006 crc_in  input  CRC_W  received CRC accompanying data_in.
REQ-007 data_in_valid  input  1  data_in/crc_in valid.
REQ-008 data_in_ready  output  1  block can capture data_in/crc_in.
REQ-009 poly  input  CRC_W+1  generator polynomial; poly[CRC_W] implied 1 and ignored.
REQ-010 poly_in_valid  input  1  poly valid.
REQ-011 poly_in_ready  output  1  block can capture poly.
REQ-012 syndrome  output  CRC_W  computed CRC XOR crc_in.
REQ-013 crc_ok  output  1  1 when syndrome is all zero.
REQ-014 outvalid  output  1  syndrome/crc_ok valid.
REQ-015 outready  input  1  downstream accepts result.

Function
REQ-016 CRC SHALL match the team's generator: zero initial remainder, no reflection, no final XOR, remainder of M(x)*x^CRC_W mod G(x).
REQ-017 Serial step per bit b: fb = r[CRC_W-1]^b; r = {r[CRC_W-2:0],0} XOR (fb ? poly[CRC_W-1:0] : 0).
REQ-018 Two message bits SHALL be processed per clock, MSB-first (bit DATA_W-1, then DATA_W-2, ...).
REQ-019 States: IDLE, CALC, DONE.
REQ-020 IDLE: data_in_ready=1 until data captured; poly_in_ready=1 until poly captured; each capture happens on a cycle with its valid&ready.
REQ-021 Data and poly MAY be captured in different cycles or the same cycle; order irrelevant.
REQ-022 IDLE->CALC on the edge at which both are held (captured earlier or in this cycle); both readies low from that edge; remainder cleared to 0 and the beat counter to 0.
REQ-023 CALC: DATA_W/2 cycles, one 2-bit step each; 4-bit (log2(DATA_W/2)) counter; CALC->DONE after the final step.
REQ-024 DONE: outvalid=1; syndrome=remainder XOR crc_in; crc_ok=(syndrome==0).
REQ-025 Outputs SHALL remain stable while outvalid=1 and outready=0.
REQ-026 On outvalid&outready, DONE->IDLE; outvalid low next cycle; both readies high next cycle; capture flags cleared.
REQ-027 Latency from final capture edge to outvalid high: DATA_W/2+1 clocks (17 for DATA_W=32).
REQ-028 valid inputs asserted outside IDLE SHALL be ignored; no capture.
REQ-029 outready asserted outside DONE SHALL have no effect.
REQ-030 syndrome and crc_ok SHALL hold their last values in IDLE and CALC; outvalid qualifies them.

Reset
REQ-031 While reset=0: state=IDLE, data_in_ready=0, poly_in_ready=0, outvalid=0, syndrome=0, crc_ok=0, capture flags=0, counter=0, remainder=0.
REQ-032 First rising clk after reset deasserts SHALL set both readies to 1.
REQ-033 Reset asserted mid-CALC or mid-DONE SHALL abort the job immediately; no result produced.

Structure
REQ-034 Shared package crc_pkg SHALL hold DATA_W/CRC_W defaults and the state enumeration, shared with the CRC generator.
REQ-035 The combinational 2-bit update (REQ-017 applied twice) SHALL be a sub-module crc_step2, reusable by the generator.
REQ-036 All flops SHALL be in one clocked process with asynchronous active-low reset; no latches.

Verification
REQ-037 poly=6'b100101, data_in=32'h0000_0001, crc_in=5'h05, both valid same cycle -> outvalid after 17 clocks, syndrome=5'h00, crc_ok=1.
REQ-038 Same poly/data, crc_in=5'h04 -> syndrome=5'h01, crc_ok=0.
REQ-039 poly first, data_in=32'h0000_0002 with crc_in=5'h0A three cycles later -> CALC starts at data capture; syndrome=0, crc_ok=1.
REQ-040 outready held 0 for 10 cycles in DONE -> outvalid, syndrome, crc_ok stable; readies stay 0; on outready=1, IDLE next cycle with both readies=1.
REQ-041 reset pulsed low at CALC cycle 8 -> outvalid never asserts; all outputs at reset values; new job afterwards gives the correct result.
REQ-042 data_in=32'h0, crc_in=5'h00, any poly -> crc_ok=1; data_in_valid toggled during CALC -> no recapture, result unchanged.
